// File: rtl/tcu_priv_reg_arbiter.sv
// tcu_priv_reg_arbiter
//
// Shares the single TCU privileged register port among NUM_REQ requesters
// (core-request unit, privileged command unit, external command unit, ...).
// One access is granted per cycle. While the register file stalls, the grant
// is locked to the same requester so the register-file address stays stable.
// Read data is returned, one cycle after acceptance, only on the slice of the
// requester whose read was accepted.
//
// Configuration:
//   TCU_PRIV_REG_ARB_RR_EN  defined   : round-robin search start (r_rr_ptr)
//                           undefined : fixed priority, index 0 highest
//
// Parameters:
//   NUM_REQ            number of requesters
//   TCU_REG_BSEL_SIZE  byte-enable width  (matches tcu_parameter.vh)
//   TCU_REG_ADDR_SIZE  address width      (matches tcu_parameter.vh)
//   TCU_REG_DATA_SIZE  data width         (matches tcu_parameter.vh)
//
// Ports:
//   clk_i        clock
//   reset_n_i    asynchronous active-low reset
//   req_en_i     per-requester access request
//   req_wben_i   per-requester byte enables (all zero = read)
//   req_addr_i   per-requester register address
//   req_wdata_i  per-requester write data
//   req_rdata_o  per-requester read data (only the read owner's slice non-zero)
//   req_stall_o  per-requester "not accepted this cycle"
//   reg_en_o     register-file access
//   reg_wben_o   byte enables to the register file
//   reg_addr_o   address to the register file
//   reg_wdata_o  write data to the register file
//   reg_rdata_i  register-file read data, valid the cycle after acceptance
//   reg_stall_i  register file busy
module tcu_priv_reg_arbiter #(
  parameter int unsigned NUM_REQ           = 3,
  parameter int unsigned TCU_REG_BSEL_SIZE = 8,
  parameter int unsigned TCU_REG_ADDR_SIZE = 32,
  parameter int unsigned TCU_REG_DATA_SIZE = 64
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [NUM_REQ-1:0]                     req_en_i,
  input  logic [NUM_REQ*TCU_REG_BSEL_SIZE-1:0]   req_wben_i,
  input  logic [NUM_REQ*TCU_REG_ADDR_SIZE-1:0]   req_addr_i,
  input  logic [NUM_REQ*TCU_REG_DATA_SIZE-1:0]   req_wdata_i,
  output logic [NUM_REQ*TCU_REG_DATA_SIZE-1:0]   req_rdata_o,
  output logic [NUM_REQ-1:0]                     req_stall_o,
  output logic                                   reg_en_o,
  output logic [TCU_REG_BSEL_SIZE-1:0]           reg_wben_o,
  output logic [TCU_REG_ADDR_SIZE-1:0]           reg_addr_o,
  output logic [TCU_REG_DATA_SIZE-1:0]           reg_wdata_o,
  input  logic [TCU_REG_DATA_SIZE-1:0]           reg_rdata_i,
  input  logic                                   reg_stall_i
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BW   = TCU_REG_BSEL_SIZE;
  localparam int unsigned AW   = TCU_REG_ADDR_SIZE;
  localparam int unsigned DW   = TCU_REG_DATA_SIZE;

  logic            locked_q, locked_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            rd_owner_vld_q, rd_owner_vld_d;
  logic [IdxW-1:0] rd_owner_q, rd_owner_d;

  logic [IdxW-1:0] search_start;
  logic            gnt_vld;
  logic [IdxW-1:0] gnt_idx;
  logic            accept;
  logic            is_read;

`ifdef TCU_PRIV_REG_ARB_RR_EN
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

  assign search_start = rr_ptr_q;

  // Next search starts just after the requester that was served.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign search_start = '0;
`endif

  // Grant selection. A locked grant is honoured only while its owner still
  // requests; if the owner drops, nothing is granted this cycle and the lock
  // falls away so the next cycle arbitrates afresh.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (locked_q) begin
      gnt_idx = lock_idx_q;
      gnt_vld = req_en_i[lock_idx_q];
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = 32'(search_start) + i;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
        if (!gnt_vld && req_en_i[IdxW'(idx)]) begin
          gnt_vld = 1'b1;
          gnt_idx = IdxW'(idx);
        end
      end
    end
  end

  // Register-file side mux; all zero when nothing is granted.
  always_comb begin
    reg_en_o    = gnt_vld;
    reg_wben_o  = '0;
    reg_addr_o  = '0;
    reg_wdata_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_vld && (gnt_idx == IdxW'(k))) begin
        reg_wben_o  = req_wben_i[k*BW +: BW];
        reg_addr_o  = req_addr_i[k*AW +: AW];
        reg_wdata_o = req_wdata_i[k*DW +: DW];
      end
    end
  end

  assign accept  = gnt_vld & ~reg_stall_i;
  assign is_read = (reg_wben_o == '0);

  always_comb begin
    req_stall_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_stall_o[k] = req_en_i[k] &
                       ~(gnt_vld & (gnt_idx == IdxW'(k)) & ~reg_stall_i);
    end
  end

  // Lock and read-owner next state.
  always_comb begin
    locked_d       = gnt_vld & reg_stall_i;
    lock_idx_d     = (gnt_vld & reg_stall_i) ? gnt_idx : lock_idx_q;
    rd_owner_vld_d = accept & is_read;
    rd_owner_d     = (accept & is_read) ? gnt_idx : '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      locked_q       <= 1'b0;
      lock_idx_q     <= '0;
      rd_owner_vld_q <= 1'b0;
      rd_owner_q     <= '0;
    end else begin
      locked_q       <= locked_d;
      lock_idx_q     <= lock_idx_d;
      rd_owner_vld_q <= rd_owner_vld_d;
      rd_owner_q     <= rd_owner_d;
    end
  end

  // Read data goes only to the requester whose read was accepted last cycle.
  always_comb begin
    req_rdata_o = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (rd_owner_vld_q && (rd_owner_q == IdxW'(k))) begin
        req_rdata_o[k*DW +: DW] = reg_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_tcu_priv_reg_arbiter.sv
// Testbench for tcu_priv_reg_arbiter: directed stimulus, a cycle-level
// behavioural model checked every cycle, plus hand-computed literal checks.
module tb_tcu_priv_reg_arbiter;

  localparam int N  = 3;
  localparam int BW = 8;
  localparam int AW = 32;
  localparam int DW = 64;
`ifdef TCU_PRIV_REG_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req_en;
  logic [N*BW-1:0] req_wben;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*DW-1:0] req_rdata;
  logic [N-1:0]    req_stall;
  logic            reg_en;
  logic [BW-1:0]   reg_wben;
  logic [AW-1:0]   reg_addr;
  logic [DW-1:0]   reg_wdata;
  logic [DW-1:0]   reg_rdata;
  logic            reg_stall;

  int checks = 0;
  int errors = 0;

  tcu_priv_reg_arbiter #(
    .NUM_REQ          (N),
    .TCU_REG_BSEL_SIZE(BW),
    .TCU_REG_ADDR_SIZE(AW),
    .TCU_REG_DATA_SIZE(DW)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .req_en_i   (req_en),
    .req_wben_i (req_wben),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_rdata_o(req_rdata),
    .req_stall_o(req_stall),
    .reg_en_o   (reg_en),
    .reg_wben_o (reg_wben),
    .reg_addr_o (reg_addr),
    .reg_wdata_o(reg_wdata),
    .reg_rdata_i(reg_rdata),
    .reg_stall_i(reg_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the port across a stall, who gets read data
  // next cycle, and where the round-robin search begins.
  int m_lock  = -1;
  int m_rd    = -1;
  int m_ptr   = 0;
  int e_win   = -1;
  bit e_acc   = 1'b0;
  bit e_rd    = 1'b0;
  bit logging = 1'b0;
  int acc_q[$];

  always @(negedge clk) begin
    int              win;
    int              start;
    logic [BW-1:0]   x_wben;
    logic [AW-1:0]   x_addr;
    logic [DW-1:0]   x_wdata;
    logic [N-1:0]    x_stall;
    logic [N*DW-1:0] x_rdata;
    win   = -1;
    start = RR ? m_ptr : 0;
    if (m_lock >= 0) begin
      if (req_en[m_lock]) win = m_lock;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (win < 0 && req_en[(start + i) % N]) win = (start + i) % N;
      end
    end
    x_wben  = (win >= 0) ? req_wben[win*BW +: BW] : '0;
    x_addr  = (win >= 0) ? req_addr[win*AW +: AW] : '0;
    x_wdata = (win >= 0) ? req_wdata[win*DW +: DW] : '0;
    for (int k = 0; k < N; k++) x_stall[k] = req_en[k] && !(k == win && !reg_stall);
    x_rdata = '0;
    if (m_rd >= 0) x_rdata[m_rd*DW +: DW] = reg_rdata;
    chk("model reg_en", 256'(reg_en), 256'(win >= 0));
    chk("model reg_wben", 256'(reg_wben), 256'(x_wben));
    chk("model reg_addr", 256'(reg_addr), 256'(x_addr));
    chk("model reg_wdata", 256'(reg_wdata), 256'(x_wdata));
    chk("model req_stall", 256'(req_stall), 256'(x_stall));
    chk("model req_rdata", 256'(req_rdata), 256'(x_rdata));
    if (logging) begin
      for (int k = 0; k < N; k++) if (req_en[k] && !req_stall[k]) acc_q.push_back(k);
    end
    e_win <= win;
    e_acc <= (win >= 0) && !reg_stall;
    e_rd  <= (win >= 0) && !reg_stall && (x_wben == '0);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_lock <= -1;
      m_rd   <= -1;
      m_ptr  <= 0;
    end else begin
      m_rd   <= e_rd ? e_win : -1;
      m_lock <= (e_win >= 0 && !e_acc) ? e_win : -1;
      if (e_acc) m_ptr <= (e_win + 1) % N;
    end
  end

  task automatic set_req(input int k, input logic en, input logic [BW-1:0] wb,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_en[k]             = en;
    req_wben[k*BW +: BW]  = wb;
    req_addr[k*AW +: AW]  = a;
    req_wdata[k*DW +: DW] = d;
  endtask

  task automatic clr_all();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, '0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N*DW-1:0] exp_rd;
    reset_n   = 1'b0;
    reg_stall = 1'b0;
    reg_rdata = '0;
    req_en    = '0;
    req_wben  = '0;
    req_addr  = '0;
    req_wdata = '0;
    #1;
    chk("reset rdata", 256'(req_rdata), 256'(0));
    chk("reset reg_en", 256'(reg_en), 256'(0));
    step();
    step();
    reset_n = 1'b1;

    // All three requesters pending for 6 acceptances.
    for (int k = 0; k < N; k++) set_req(k, 1'b1, '0, AW'(32'h100 + k), '0);
    logging = 1'b1;
    repeat (6) step();
    logging = 1'b0;
    clr_all();
    chk("all-pending acceptance count", 256'(acc_q.size()), 256'(6));
    for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
      chk("all-pending acceptance order", 256'(acc_q[i]), 256'(RR ? (i % 3) : 0));
    end

    // Single read, fixed latency.
    set_req(1, 1'b1, '0, 32'h10, '0);
    @(negedge clk);
    chk("read req1 stall", 256'(req_stall[1]), 256'(0));
    chk("read req1 addr", 256'(reg_addr), 256'(32'h10));
    step();
    clr_all();
    reg_rdata = 64'hA5;
    @(negedge clk);
    chk("read slice1", 256'(req_rdata[1*DW +: DW]), 256'(64'hA5));
    chk("read slice0", 256'(req_rdata[0*DW +: DW]), 256'(0));
    chk("read slice2", 256'(req_rdata[2*DW +: DW]), 256'(0));
    step();
    reg_rdata = '0;

    // Lock across stall: req2 write, req0 arrives in cycle 2.
    reg_stall = 1'b1;
    set_req(2, 1'b1, 8'hFF, 32'h20, 64'hCAFE);
    @(negedge clk);
    chk("lock c1 addr", 256'(reg_addr), 256'(32'h20));
    step();
    set_req(0, 1'b1, '0, 32'h30, '0);
    @(negedge clk);
    chk("lock c2 addr", 256'(reg_addr), 256'(32'h20));
    chk("lock c2 req0 stall", 256'(req_stall[0]), 256'(1));
    step();
    @(negedge clk);
    chk("lock c3 addr", 256'(reg_addr), 256'(32'h20));
    step();
    reg_stall = 1'b0;
    @(negedge clk);
    chk("lock c4 addr", 256'(reg_addr), 256'(32'h20));
    chk("lock c4 req2 accepted", 256'(req_stall[2]), 256'(0));
    chk("lock c4 req0 stall", 256'(req_stall[0]), 256'(1));
    step();
    set_req(2, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("lock c5 req0 accepted", 256'(req_stall[0]), 256'(0));
    chk("lock c5 addr", 256'(reg_addr), 256'(32'h30));
    step();
    clr_all();
    reg_rdata = 64'hBEEF;
    @(negedge clk);
    chk("lock c6 rdata slice0", 256'(req_rdata[0*DW +: DW]), 256'(64'hBEEF));
    step();
    reg_rdata = '0;

    // Locked requester drops its request.
    reg_stall = 1'b1;
    set_req(2, 1'b1, 8'h01, 32'h80, 64'h5);
    @(negedge clk);
    chk("drop c1 reg_en", 256'(reg_en), 256'(1));
    step();
    set_req(2, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, '0, 32'h90, '0);
    @(negedge clk);
    chk("drop c2 reg_en", 256'(reg_en), 256'(0));
    chk("drop c2 req1 stall", 256'(req_stall[1]), 256'(1));
    step();
    reg_stall = 1'b0;
    @(negedge clk);
    chk("drop c3 addr", 256'(reg_addr), 256'(32'h90));
    chk("drop c3 req1 accepted", 256'(req_stall[1]), 256'(0));
    step();
    clr_all();
    step();

    // Back-to-back write then read.
    set_req(0, 1'b1, 8'h0F, 32'h40, 64'h1111);
    @(negedge clk);
    chk("b2b write accepted", 256'(req_stall[0]), 256'(0));
    step();
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, '0, 32'h50, '0);
    @(negedge clk);
    chk("b2b read reg_en", 256'(reg_en), 256'(1));
    chk("b2b read addr", 256'(reg_addr), 256'(32'h50));
    chk("b2b read accepted", 256'(req_stall[1]), 256'(0));
    chk("b2b no data after write", 256'(req_rdata), 256'(0));
    step();
    clr_all();
    reg_rdata = 64'h1234;
    @(negedge clk);
    exp_rd = '0;
    exp_rd[1*DW +: DW] = 64'h1234;
    chk("b2b rdata routing", 256'(req_rdata), 256'(exp_rd));
    step();
    reg_rdata = '0;

    // Async reset while req1 is locked in a stall, req0 pending.
    reg_stall = 1'b1;
    set_req(1, 1'b1, '0, 32'h60, '0);
    @(negedge clk);
    chk("rst lock addr", 256'(reg_addr), 256'(32'h60));
    step();
    set_req(0, 1'b1, '0, 32'h70, '0);
    @(negedge clk);
    chk("rst locked keeps addr", 256'(reg_addr), 256'(32'h60));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst lock cleared addr", 256'(reg_addr), 256'(32'h70));
    chk("rst stall vector", 256'(req_stall), 256'(3'b011));
    chk("rst rdata zero", 256'(req_rdata), 256'(0));
    step();
    step();
    reg_stall = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);
    chk("post-rst req0 first", 256'(req_stall[0]), 256'(0));
    chk("post-rst addr", 256'(reg_addr), 256'(32'h70));
    chk("post-rst req1 stall", 256'(req_stall[1]), 256'(1));
    step();
    set_req(0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("post-rst req1 next", 256'(req_stall[1]), 256'(0));
    step();
    clr_all();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
